// File: rtl/bkm_iter_csd_if.sv
// Bus between the BKM iteration engine and its digit-selection / CSD multiplier side.
interface bkm_iter_csd_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned N_ITER = 8
);
  localparam int unsigned IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  logic                 start;
  logic signed [W-1:0]  x0;
  logic signed [W-1:0]  y0;
  logic                 d_valid;
  logic [2*W-1:0]       cur_x_csd;
  logic [2*W-1:0]       cur_y_csd;
  logic [2*W-1:0]       prod_x_csd;
  logic [2*W-1:0]       prod_y_csd;
  logic [IW-1:0]        iter;
  logic                 busy;
  logic                 done;
  logic                 res_valid;
  logic signed [W-1:0]  x_res;
  logic signed [W-1:0]  y_res;

  modport master (
    output start, x0, y0, d_valid, prod_x_csd, prod_y_csd,
    input  cur_x_csd, cur_y_csd, iter, busy, done, res_valid, x_res, y_res
  );

  modport slave (
    input  start, x0, y0, d_valid, prod_x_csd, prod_y_csd,
    output cur_x_csd, cur_y_csd, iter, busy, done, res_valid, x_res, y_res
  );
endinterface

// File: rtl/bkm_iter_csd.sv
// BKM iteration engine: holds X+iY, exports it in CSD form, and accumulates the
// returned CSD product shifted by the iteration index for N_ITER accepted steps.
module bkm_iter_csd #(
  parameter int unsigned W      = 8,
  parameter int unsigned N_ITER = 8
) (
  input  logic           clk,
  input  logic           rst,
  bkm_iter_csd_if.slave  bus
);
  localparam int unsigned IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic [IW-1:0]       n_q;
  logic                busy_q;
  logic                done_q;
  logic                rv_q;

  // Reitwiesner recoding: a digit is nonzero exactly when x_k + c_k is odd;
  // its sign is negative when that position also generates a carry.
  function automatic logic [2*W-1:0] to_csd(input logic [W-1:0] x);
    logic [W:0]     xe;
    logic           c;
    logic           cn;
    logic [2*W-1:0] r;
    xe = {x[W-1], x};
    c  = 1'b0;
    r  = '0;
    for (int k = 0; k < W; k++) begin
      cn         = (xe[k] & xe[k+1]) | (xe[k] & c) | (xe[k+1] & c);
      r[2*k]     = (xe[k] ^ c) & ~cn;
      r[2*k+1]   = (xe[k] ^ c) & cn;
      c          = cn;
    end
    return r;
  endfunction

  // Digits with both flags set contribute nothing.
  function automatic logic [W-1:0] from_csd(input logic [2*W-1:0] d);
    logic [W-1:0] pos;
    logic [W-1:0] neg;
    for (int k = 0; k < W; k++) begin
      pos[k] = d[2*k] & ~d[2*k+1];
      neg[k] = d[2*k+1] & ~d[2*k];
    end
    return pos - neg;
  endfunction

  logic signed [W-1:0] px;
  logic signed [W-1:0] py;

  assign px = signed'(from_csd(bus.prod_x_csd));
  assign py = signed'(from_csd(bus.prod_y_csd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) rv_q <= 1'b1;
          // A start in DONE restarts immediately and invalidates the result.
          if (bus.start) begin
            x_q    <= bus.x0;
            y_q    <= bus.y0;
            n_q    <= '0;
            rv_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          if (bus.d_valid) begin
            x_q <= x_q + (px >>> n_q);
            y_q <= y_q + (py >>> n_q);
            if (n_q == LAST) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              n_q <= n_q + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cur_x_csd = to_csd(x_q);
  assign bus.cur_y_csd = to_csd(y_q);
  assign bus.iter      = n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = rv_q;
  assign bus.x_res     = x_q;
  assign bus.y_res     = y_q;

endmodule

// File: tb/tb_bkm_iter_csd.sv
// Bench for bkm_iter_csd: loopback multiplier (d=1), behavioural model checked every
// cycle, plus directed scenarios with hand-computed results.
module tb_bkm_iter_csd;
  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inject = 1'b0;
  logic check_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  bkm_iter_csd_if #(.W(W), .N_ITER(N)) bus ();
  bkm_iter_csd #(.W(W), .N_ITER(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Value of a CSD word; illegal digits count as zero.
  function automatic logic signed [7:0] dec(input logic [15:0] c);
    int v;
    v = 0;
    for (int k = 0; k < 8; k++) begin
      case (c[2*k +: 2])
        2'b01:   v = v + (1 << k);
        2'b10:   v = v - (1 << k);
        default: v = v;
      endcase
    end
    return 8'(v);
  endfunction

  // Canonical: no illegal digit, no two adjacent nonzero digits.
  function automatic logic csd_ok(input logic [15:0] c);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (c[2*k +: 2] == 2'b11) ok = 1'b0;
      if (k < 7 && c[2*k +: 2] != 2'b00 && c[2*k+2 +: 2] != 2'b00) ok = 1'b0;
    end
    return ok;
  endfunction

  // Product equal to the iterate, with zero digits turned into illegal 2'b11 digits.
  function automatic logic [15:0] add_illegal(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      if (c[2*k +: 2] == 2'b00) r[2*k +: 2] = 2'b11;
    return r;
  endfunction

  assign bus.prod_x_csd = inject ? add_illegal(bus.cur_x_csd) : bus.cur_x_csd;
  assign bus.prod_y_csd = inject ? add_illegal(bus.cur_y_csd) : bus.cur_y_csd;

  task automatic check(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 run, 2 done.
  int                 m_st = 0;
  int                 m_n  = 0;
  logic signed [7:0]  m_x  = '0;
  logic signed [7:0]  m_y  = '0;
  logic               m_rv = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0; m_n <= 0; m_x <= '0; m_y <= '0; m_rv <= 1'b0;
    end else if (m_st == 1) begin
      if (bus.d_valid) begin
        m_x <= m_x + (dec(bus.prod_x_csd) >>> m_n);
        m_y <= m_y + (dec(bus.prod_y_csd) >>> m_n);
        if (m_n == N - 1) m_st <= 2;
        else              m_n  <= m_n + 1;
      end
    end else if (bus.start) begin
      m_x <= bus.x0; m_y <= bus.y0; m_n <= 0; m_rv <= 1'b0; m_st <= 1;
    end else begin
      if (m_st == 2) m_rv <= 1'b1;
      m_st <= 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cmp_busy", 32'(bus.busy), 32'(m_st == 1));
      check("cmp_done", 32'(bus.done), 32'(m_st == 2));
      check("cmp_res_valid", 32'(bus.res_valid), 32'(m_rv));
      check("cmp_iter", 32'(bus.iter), m_n);
      check("cmp_x_res", bus.x_res, m_x);
      check("cmp_y_res", bus.y_res, m_y);
      check("cmp_cur_x_val", dec(bus.cur_x_csd), m_x);
      check("cmp_cur_y_val", dec(bus.cur_y_csd), m_y);
      check("cmp_cur_x_form", 32'(csd_ok(bus.cur_x_csd)), 1);
      check("cmp_cur_y_form", 32'(csd_ok(bus.cur_y_csd)), 1);
    end
  end

  // Waits for done from the cycle after a start; optional d_valid gap and stray start.
  task automatic wait_done(input int gap_at, input int gap_len, input int poke_at,
                           input int exp_lat, input string nm);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      bus.start = (cnt == poke_at);
      if (cnt == poke_at) begin
        bus.x0 = 8'sd100;
        bus.y0 = 8'sd100;
      end
      bus.d_valid = !(cnt >= gap_at && cnt < gap_at + gap_len);
      if (gap_len > 0 && cnt == gap_at + gap_len - 1) begin
        check({nm, "_gap_iter"}, 32'(bus.iter), 2);
        check({nm, "_gap_x"}, bus.x_res, 48);
      end
      if (bus.done) seen = 1;
    end
    check({nm, "_latency"}, seen ? cnt : -1, exp_lat);
  endtask

  task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b,
                        input int gap_at, input int gap_len, input int poke_at,
                        input int exp_lat, input int ex, input int ey, input string nm);
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = a; bus.y0 = b; bus.d_valid = 1'b1;
    wait_done(gap_at, gap_len, poke_at, exp_lat, nm);
    @(negedge clk);
    check({nm, "_res_valid"}, 32'(bus.res_valid), 1);
    check({nm, "_x_res"}, bus.x_res, ex);
    check({nm, "_y_res"}, bus.y_res, ey);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_hold(input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic [15:0] ecx, input logic [15:0] ecy, input string nm);
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = a; bus.y0 = b; bus.d_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check({nm, "_cur_x"}, 32'(bus.cur_x_csd), 32'(ecx));
    check({nm, "_cur_y"}, 32'(bus.cur_y_csd), 32'(ecy));
  endtask

  initial begin
    bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_iter", 32'(bus.iter), 0);
    check("rst_x_res", bus.x_res, 0);
    check("rst_cur_x", 32'(bus.cur_x_csd), 0);
    rst = 1'b1;
    check_en = 1'b1;

    load_hold(8'sd7, -8'sd1, 16'h0042, 16'h0002, "enc_a");
    pulse_reset();
    load_hold(8'sd0, -8'sd128, 16'h0000, 16'h8000, "enc_b");
    pulse_reset();

    run_op(8'sd16, -8'sd16, 0, 0, 0, 9, 74, -79, "loop");
    run_op(8'sd16, -8'sd16, 3, 3, 0, 12, 74, -79, "gap");
    run_op(8'sd16, -8'sd16, 0, 0, 5, 9, 74, -79, "poke");

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = 8'sd16; bus.y0 = -8'sd16; bus.d_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_iter_before", 32'(bus.iter), 3);
    #2 rst = 1'b0;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_done", 32'(bus.done), 0);
    check("mid_res_valid", 32'(bus.res_valid), 0);
    check("mid_iter", 32'(bus.iter), 0);
    check("mid_x_res", bus.x_res, 0);
    check("mid_y_res", bus.y_res, 0);
    check("mid_cur_y", 32'(bus.cur_y_csd), 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'sd16, -8'sd16, 0, 0, 0, 9, 74, -79, "after_rst");

    // Back-to-back with illegal digits injected into the product.
    inject = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = 8'sd16; bus.y0 = -8'sd16; bus.d_valid = 1'b1;
    wait_done(0, 0, 0, 9, "b2b_first");
    check("b2b_first_x", bus.x_res, 74);
    check("b2b_first_y", bus.y_res, -79);
    check("b2b_done_busy", 32'(bus.busy), 0);
    bus.start = 1'b1; bus.x0 = -8'sd16; bus.y0 = 8'sd16;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_restart_busy", 32'(bus.busy), 1);
    check("b2b_restart_done", 32'(bus.done), 0);
    check("b2b_restart_rv", 32'(bus.res_valid), 0);
    check("b2b_restart_x", bus.x_res, -16);
    wait_done(0, 0, 0, 8, "b2b_second");
    @(negedge clk);
    check("b2b_second_rv", 32'(bus.res_valid), 1);
    check("b2b_second_x", bus.x_res, -79);
    check("b2b_second_y", bus.y_res, 74);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bkm_iter_csd.md
# bkm_iter_csd

Sequential BKM iteration engine that closes the loop around the combinational `multiply_by_d_csd` stage. It holds the complex iterate X+iY in binary registers and presents it to the multiplier in canonical signed-digit (CSD) form. It takes back the CSD product d·(X+iY) and performs one update X ← X + P·2^-n per accepted step for N_ITER steps, then presents the result. The digit-selection logic drives `d_x`/`d_y` into the multiplier directly and paces this block with `d_valid`.

## Interface
- W, 8: datapath width in bits (two's complement); CSD buses are 2W bits
- N_ITER, 8: iterations per operation, 1 ≤ N_ITER ≤ W
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin operation; accepted only when busy=0
- x0, y0  in  W  signed initial iterate, sampled with accepted start
- d_valid  in  1  digits and product valid this cycle; step advances only when 1
- cur_x_csd, cur_y_csd  out  2W  CSD form of current X, Y (combinational from registers), to multiplier x_in/y_in
- prod_x_csd, prod_y_csd  in  2W  CSD product from multiplier x_out/y_out
- iter  out  ceil(log2(N_ITER)) (min 1)  current shift index n
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result just completed
- res_valid  out  1  x_res/y_res hold a completed result
- x_res, y_res  out  W  signed X, Y registers

## Operation
- CSD encoding: digit k occupies bits [2k+1:2k]; bit 2k = +1 flag, bit 2k+1 = −1 flag; value = Σ(pos_k − neg_k)·2^k mod 2^W; both flags set is illegal, treat as 0.
- bin→CSD (Reitwiesner): x_W := x_{W-1}, c_0 = 0, c_{k+1} = x_k·x_{k+1} | x_k·c_k | x_{k+1}·c_k, digit_k = x_k + c_k − 2c_{k+1}, k = 0..W-1.
- CSD→bin: P = pos_vector − neg_vector, W bits, wrap mod 2^W.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → load X=x0, Y=y0, n=0, clear res_valid, go RUN.
  - RUN: d_valid=1 → X ← X + (Px >>> n), Y ← Y + (Py >>> n), all W-bit wrap, arithmetic shift. If n = N_ITER−1, go DONE with n unchanged; else n ← n+1. d_valid=0 → hold everything.
  - DONE: done=1, res_valid ← 1, go IDLE; start=1 here is accepted exactly as in IDLE (next state RUN, done still 1 this cycle).
- start while busy=1: ignored, no effect.
- x0/y0 sampled only on the accepting edge.

## Timing
- Reset values: state IDLE, X=Y=0, n=0; busy=0, done=0, res_valid=0, iter=0, x_res=y_res=0, cur_*_csd=0.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- Start accepted at edge E0: busy=1 from E0. With d_valid held at 1, updates occur at edges E1..E_N_ITER. DONE occupies the following cycle (done=1, busy=0). res_valid rises at the next edge.
- Latency from start to done with no stalls is N_ITER+1 cycles; each d_valid=0 cycle in RUN adds one.
- Multiplier path is combinational: cur_*_csd → multiply_by_d_csd → prod_*_csd within one cycle.
- iter is valid in RUN; it equals N_ITER−1 in DONE.

## Test plan
- CSD encoder, W=8: X=7 → cur_x_csd=16'h0042; X=−1 → 16'h0002; X=0 → 16'h0000; X=−128 → value −128 mod 256, no adjacent nonzero digits.
- Loopback (prod=cur, d=1), x0=16, y0=−16, d_valid=1 → done 9 cycles after start; x_res=74, y_res=−79; res_valid=1.
- Same as loopback with d_valid low for 3 cycles at n=2 → iter and X/Y frozen during the gap; done 12 cycles after start; x_res=74, y_res=−79.
- start pulsed at n=4 of a run with x0=100 → ignored; the original result (74, −79) is unchanged.
- Assert rst low at n=3 → all outputs return to reset values asynchronously; a new start with x0=16 then yields 74 again.
- Back-to-back: start held high through DONE → done=1 and a new RUN begin in the same cycle; the second result is correct. prod with both flags set in a digit is treated as 0.
